// File: rtl/fifo_tx_serializer_if.sv
// ============================================================================
// fifo_tx_serializer_if : FIFO read port, control and serial-line bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  tx;
  logic                  busy;
  logic                  byte_done;

  // master: the serializer itself; slave: FIFO / controller side
  modport master (
    input  enable, fifo_empty, fifo_rd_data,
    output fifo_rd, tx, busy, byte_done
  );

  modport slave (
    output enable, fifo_empty, fifo_rd_data,
    input  fifo_rd, tx, busy, byte_done
  );
endinterface

`default_nettype wire

// File: rtl/fifo_tx_serializer.sv
// ============================================================================
// fifo_tx_serializer : pops FIFO words and sends them as async serial frames
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  wire logic              clock_i,
  input  wire logic              rst_ni,
  fifo_tx_serializer_if.master   bus_io
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX);

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  C_STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LATCH  = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  w_baud_end;
  logic [DATA_WIDTH-1:0] w_shift_nx;

  assign w_baud_end = (baud_q == C_BAUD_LAST);
  assign w_shift_nx = shift_q >> 1;

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Bit-timed states share one baud counter; transitions happen on its last count
    if ((state_q == S_START) || (state_q == S_DATA) ||
        (state_q == S_PARITY) || (state_q == S_STOP)) begin
      baud_d = w_baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus_io.enable && !bus_io.fifo_empty) begin
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d  = bus_io.fifo_rd_data;
        parity_d = ^bus_io.fifo_rd_data;
        tx_d     = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end
      S_START: begin
        if (w_baud_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (bit_q == C_DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = w_shift_nx;
            tx_d    = w_shift_nx[0];
          end
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (bit_q == C_STOP_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_io.fifo_rd   = rd_q;
  assign bus_io.tx        = tx_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.byte_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_tx_serializer.sv
// ============================================================================
// tb_fifo_tx_serializer : scoreboard bench, two configurations side by side
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_tx_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   env_done [2];

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, then idle-high stop
  function automatic logic model_bit(input logic [DW-1:0] w, input int idx, input int par);
    if (idx == 0)                    return 1'b0;
    if (idx <= DW)                   return w[idx-1];
    if ((par != 0) && (idx == DW+1)) return ^w;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int P = g;
    localparam int S = g + 1;
    localparam int L = (1 + DW + P + S) * CPB;

    logic rst_n;
    fifo_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_tx_serializer #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (P),
      .STOP_BITS   (S)
    ) u_dut (
      .clock_i(clk),
      .rst_ni (rst_n),
      .bus_io (bus)
    );

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sb_q   [$];
    bit            stall = 1'b0;
    bit            rand_mode = 1'b0;
    int            frames = 0, pops = 0, last_gap = 0, gap = 0, cyc = 0, rd_cyc = 0;
    int            width_err = 0, spur_err = 0;
    bit            mon_active = 1'b0, pending = 1'b0;
    int            mon_idx = 0, mon_err = 0;
    logic [DW-1:0] mon_word = '0;
    logic          prev_rd = 1'b0, prev_empty = 1'b1, prev_busy = 1'b0;

    // FIFO model: a pop at this edge delivers data for the next cycle
    always @(posedge clk) begin
      logic [DW-1:0] w;
      if (bus.fifo_rd) begin
        check(fifo_q.size() != 0, $sformatf("env%0d underflow", g), fifo_q.size(), 1);
        w = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
        bus.fifo_rd_data = w;
        sb_q.push_back(w);
      end
      #1;
      stall = rand_mode ? ($urandom_range(3) == 0) : 1'b0;
      bus.fifo_empty = (fifo_q.size() == 0) || stall;
    end

    // Line monitor: decodes each frame cycle by cycle against the model
    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        mon_active = 1'b0;
        pending    = 1'b0;
        gap        = 0;
        sb_q.delete();
      end else begin
        if (bus.fifo_rd) begin
          if (prev_rd) width_err++;
          else begin
            pops++;
            rd_cyc = cyc;
            check(!prev_empty, $sformatf("env%0d pop_on_empty", g), prev_empty, 0);
            check(!prev_busy, $sformatf("env%0d pop_while_busy", g), prev_busy, 0);
          end
        end
        if (pending) begin
          check(bus.byte_done && !bus.busy, $sformatf("env%0d byte_done", g),
                {bus.byte_done, bus.busy}, 2);
          frames++;
          pending = 1'b0;
        end else if (bus.byte_done) begin
          spur_err++;
        end
        if (!mon_active) begin
          if (bus.tx == 1'b0) begin
            check(sb_q.size() != 0, $sformatf("env%0d frame_expected", g), sb_q.size(), 1);
            mon_word = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
            check(cyc - rd_cyc == 2, $sformatf("env%0d start_latency", g), cyc - rd_cyc, 2);
            check(gap >= 3, $sformatf("env%0d idle_gap", g), gap, 3);
            last_gap   = gap;
            mon_active = 1'b1;
            mon_idx    = 0;
            mon_err    = 0;
          end else begin
            gap++;
          end
        end
        if (mon_active) begin
          if ((bus.tx !== model_bit(mon_word, mon_idx / CPB, P)) || !bus.busy) mon_err++;
          mon_idx++;
          if (mon_idx == L) begin
            check(mon_err == 0, $sformatf("env%0d frame word=0x%02h bad_cycles", g, mon_word),
                  mon_err, 0);
            mon_active = 1'b0;
            pending    = 1'b1;
            gap        = 0;
          end
        end
      end
      prev_rd    = bus.fifo_rd;
      prev_empty = bus.fifo_empty;
      prev_busy  = bus.busy;
    end

    initial begin
      int f0, p0;
      rst_n      = 1'b0;
      bus.enable = 1'b1;
      fifo_q.push_back(8'hA5);
      repeat (2) begin @(negedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
        check({bus.tx, bus.fifo_rd, bus.busy, bus.byte_done} == 4'b1000,
              $sformatf("env%0d reset_outputs", g),
              {bus.tx, bus.fifo_rd, bus.busy, bus.byte_done}, 8);
        @(negedge clk); #1;
      end

      // single word
      f0 = frames;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int t = 0; t < 300 && frames == f0; t++) begin @(negedge clk); #1; end
      check(frames == f0 + 1, $sformatf("env%0d single_frame", g), frames - f0, 1);
      repeat (20) begin @(negedge clk); #1; end
      check(pops == 1, $sformatf("env%0d single_pops", g), pops, 1);

      // back-to-back
      f0 = frames; p0 = pops;
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hFF);
      for (int t = 0; t < 600 && frames < f0 + 2; t++) begin @(negedge clk); #1; end
      check(frames == f0 + 2, $sformatf("env%0d b2b_frames", g), frames - f0, 2);
      check(pops == p0 + 2, $sformatf("env%0d b2b_pops", g), pops - p0, 2);
      check(last_gap == 3, $sformatf("env%0d b2b_gap", g), last_gap, 3);

      // empty FIFO
      begin
        int bad = 0;
        p0 = pops;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk); #1;
          if (!bus.tx || bus.busy || bus.fifo_rd) bad++;
        end
        check(bad == 0, $sformatf("env%0d empty_idle_bad_cycles", g), bad, 0);
        check(pops == p0, $sformatf("env%0d empty_pops", g), pops - p0, 0);
      end

      // parity word
      f0 = frames;
      fifo_q.push_back(8'h07);
      for (int t = 0; t < 300 && frames == f0; t++) begin @(negedge clk); #1; end
      check(frames == f0 + 1, $sformatf("env%0d parity_frame", g), frames - f0, 1);

      // enable dropped during data bit 3
      f0 = frames; p0 = pops;
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'h96);
      fifo_q.push_back(8'h5A);
      for (int t = 0; t < 300 && !(mon_active && mon_idx >= CPB*4 + 1); t++) begin
        @(negedge clk); #1;
      end
      bus.enable = 1'b0;
      for (int t = 0; t < 300 && frames == f0; t++) begin @(negedge clk); #1; end
      repeat (60) begin @(negedge clk); #1; end
      check(pops == p0 + 1, $sformatf("env%0d en_drop_pops", g), pops - p0, 1);
      check(fifo_q.size() == 2, $sformatf("env%0d en_drop_left", g), fifo_q.size(), 2);

      // reset during data bit 5
      bus.enable = 1'b1;
      for (int t = 0; t < 300 && !(mon_active && mon_idx >= CPB*6 + 1); t++) begin
        @(negedge clk); #1;
      end
      #1 rst_n = 1'b0;
      #1;
      check({bus.tx, bus.busy} == 2'b10, $sformatf("env%0d reset_abort", g),
            {bus.tx, bus.busy}, 2);
      repeat (3) begin @(negedge clk); #1; end
      f0 = frames; p0 = pops;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int t = 0; t < 300 && frames == f0; t++) begin @(negedge clk); #1; end
      check(frames == f0 + 1, $sformatf("env%0d post_reset_frame", g), frames - f0, 1);
      check(pops == p0 + 1, $sformatf("env%0d post_reset_pops", g), pops - p0, 1);
      check(fifo_q.size() == 0, $sformatf("env%0d post_reset_left", g), fifo_q.size(), 0);

      // randomized traffic with stalls and enable toggling
      rand_mode = 1'b1;
      for (int i = 0; i < 16; i++) fifo_q.push_back(DW'($urandom));
      begin
        int t;
        for (t = 0; t < 10000; t++) begin
          @(negedge clk); #1;
          bus.enable = ($urandom_range(3) != 0);
          if (fifo_q.size() == 0 && sb_q.size() == 0 && !mon_active && !pending && !bus.busy)
            break;
        end
        check(t < 10000, $sformatf("env%0d random_timeout", g), t, 10000);
      end
      rand_mode  = 1'b0;
      bus.enable = 1'b1;
      repeat (10) begin @(negedge clk); #1; end
      check(frames == 22, $sformatf("env%0d total_frames", g), frames, 22);
      check(pops == 23, $sformatf("env%0d total_pops", g), pops, 23);
      check(width_err == 0, $sformatf("env%0d rd_pulse_width_errors", g), width_err, 0);
      check(spur_err == 0, $sformatf("env%0d spurious_byte_done", g), spur_err, 0);
      check(sb_q.size() == 0, $sformatf("env%0d scoreboard_left", g), sb_q.size(), 0);
      env_done[g] = 1'b1;
    end
  end

  initial begin
    int t;
    for (t = 0; t < 60000 && !(env_done[0] && env_done[1]); t++) @(negedge clk);
    check(env_done[0] && env_done[1], "env_timeout", {env_done[0], env_done[1]}, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
Downstream consumer of the FIFO: pops one word at a time through the FIFO read port (rd / rd_data / empty) and shifts it out as an asynchronous serial frame (start bit, data LSB-first, optional even parity, stop bits). Single clock domain. It is the transmit-side drain that turns buffered parallel data into a serial line.

Parameters:
DATA_WIDTH, 8, width of the FIFO word and of the serial data field.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
enable  input  1  level; 1 permits new pops; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_rd  output  1  FIFO read strobe, registered, one-cycle pulse per word.
fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid one cycle after the cycle fifo_rd is high.
tx  output  1  serial line, idle high, registered.
busy  output  1  high from the POP state through the end of STOP.
byte_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (rst=0, async): state IDLE; tx=1, fifo_rd=0, busy=0, byte_done=0; bit counter, baud counter and shift register cleared. Reset mid-frame aborts immediately: tx returns high without waiting for a clock edge. The already-popped word is discarded, not re-read.
- States: IDLE -> POP -> LATCH -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: at edge k, if enable=1 and fifo_empty=0, set fifo_rd=1 and go to POP. Otherwise hold, with tx=1.
- POP: fifo_rd is high for exactly the cycle k..k+1, and the FIFO pops at edge k+1. At edge k+1 clear fifo_rd and go to LATCH.
- LATCH: at edge k+2 capture fifo_rd_data into the shift register, compute parity = XOR of the data, drive tx=0 and go to START.
- START, DATA, PARITY and STOP each hold for CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
- DATA: DATA_WIDTH bits, LSB first.
- PARITY: present only if PARITY_EN=1.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length on tx: (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- End of STOP (edge m): byte_done=1 for cycle m..m+1, busy=0, go to IDLE. If the pop condition holds at edge m+1, the next start bit begins at edge m+3, giving 3 extra idle-high cycles between frames.
- fifo_rd is never asserted in any state other than IDLE->POP. It is never asserted when fifo_empty=1 at the sampling edge, so there is no FIFO underflow.
- enable deasserted mid-frame: the current frame completes normally; no further pop occurs.
- fifo_empty going high mid-frame has no effect on the current frame.
- Counters are sized $clog2 of their maximum value and wrap only by explicit reload; no arithmetic overflow is possible.

Test Plan:
1. Reset check (CLKS_PER_BIT=4): hold rst=0 with enable=1 and fifo_empty=0 -> tx=1, fifo_rd=0, busy=0, byte_done=0 throughout reset.
2. Single word 0xA5 (PARITY_EN=0): exactly one fifo_rd pulse; tx falls 2 cycles after the sampling edge; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 clocks total); one byte_done pulse.
3. Back-to-back 0x00 then 0xFF: exactly two fifo_rd pulses, with no pop while busy=1; 3 extra idle-high cycles between the first stop bit and the second start bit; decoded bytes are 0x00 then 0xFF.
4. Empty FIFO: enable=1 and fifo_empty=1 for 200 clocks -> fifo_rd never asserted, tx=1, busy=0.
5. Parity (PARITY_EN=1, STOP_BITS=2): word 0x07 -> parity bit 1; frame 0,1,1,1,0,0,0,0,0,1,1,1 (48 clocks).
6. Interruptions:
   - Drop enable during data bit 3 -> frame completes, then no further pop while 2 words remain.
   - Assert rst during data bit 5 -> tx=1 within the same cycle and busy=0.
   - After reset release with enable=1 -> the next FIFO word is popped and sent intact.
